sonic_echo_emulator: RTL and testbench

Cycle-accurate model of the HC-SR04 ultrasonic sensor as seen from the FPGA side. It accepts the trigger pulse from the sonic controller and answers with an echo pulse whose width encodes a programmed distance. It is used in the sonic test harness and on-board, looped back into the controller, so the distance path can be exercised without a physical sensor.

---
 rtl/sonic_echo_emulator.sv | 157 +++++++++++++++
 tb/tb_sonic_echo_emulator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sonic_echo_emulator.sv
// Purpose: HC-SR04 ultrasonic sensor emulator. It answers a trigger pulse with an echo
//          pulse whose width encodes distance_cm (clamped), or a timeout width.
// Latency: echo rises DELAY_US*CLK_PER_US+2 clk after the first clk that samples trig low.
// Backpressure: none. Triggers while busy are ignored. Short triggers are rejected with trig_err.
// Ports:   clk, rst (async active-high); trig (async in); distance_cm[8:0] and no_object
//          (sampled at trigger acceptance); echo, busy, trig_err (all registered outputs).
module sonic_echo_emulator #(
    parameter int CLK_PER_US  = 100,
    parameter int MIN_TRIG_US = 10,
    parameter int DELAY_US    = 500,
    parameter int US_PER_CM   = 58,
    parameter int MIN_CM      = 2,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    input  logic       no_object,
    output logic       echo,
    output logic       busy,
    output logic       trig_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG_HI = 3'd1,
        S_DELAY   = 3'd2,
        S_ECHO    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    localparam int              PSC_W      = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX   = PSC_W'(CLK_PER_US - 1);
    localparam logic [15:0]     TRIG_MIN   = 16'(MIN_TRIG_US * CLK_PER_US);
    localparam logic [15:0]     DELAY_LAST = 16'(DELAY_US - 1);
    localparam logic [15:0]     HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0]     TIMEOUT_V  = 16'(TIMEOUT_US);
    localparam logic [15:0]     US_CM_V    = 16'(US_PER_CM);
    localparam logic [8:0]      MIN_CM_V   = 9'(MIN_CM);
    localparam logic [8:0]      MAX_CM_V   = 9'(MAX_CM);

    state_t           state_q, state_d;
    logic             trig_s1_q, trig_s1_d;
    logic             ts_q, ts_d;
    logic             ts_dly_q, ts_dly_d;     // delayed copy of ts for edge detection
    logic [15:0]      hi_cnt_q, hi_cnt_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [15:0]      us_q, us_d;
    logic [15:0]      echo_us_q, echo_us_d;
    logic             echo_q, echo_d;
    logic             busy_q, busy_d;
    logic             trig_err_q, trig_err_d;

    logic             tick;
    logic [8:0]       dist_eff;
    logic [15:0]      meas_us;

    // Echo width for the current inputs; only captured on the TRIG_HI->DELAY edge.
    always_comb begin
        dist_eff = (distance_cm < MIN_CM_V) ? MIN_CM_V : distance_cm;
        if (no_object || (distance_cm > MAX_CM_V)) begin
            meas_us = TIMEOUT_V;
        end else begin
            meas_us = 16'({7'd0, dist_eff} * US_CM_V);
        end
    end

    always_comb begin
        trig_s1_d  = trig;
        ts_d       = trig_s1_q;
        ts_dly_d   = ts_q;
        state_d    = state_q;
        hi_cnt_d   = hi_cnt_q;
        echo_us_d  = echo_us_q;
        trig_err_d = 1'b0;

        tick = (psc_q == PSC_MAX);
        psc_d = tick ? '0 : psc_q + 1'b1;
        us_d  = tick ? us_q + 16'd1 : us_q;

        unique case (state_q)
            S_IDLE: begin
                // Rising edge only, so a trig still high on entry is ignored.
                if (ts_q && !ts_dly_q) begin
                    state_d  = S_TRIG_HI;
                    hi_cnt_d = 16'd1;
                end
            end
            S_TRIG_HI: begin
                if (ts_q) begin
                    if (hi_cnt_q != 16'hFFFF) hi_cnt_d = hi_cnt_q + 16'd1;
                end else if (hi_cnt_q >= TRIG_MIN) begin
                    state_d   = S_DELAY;
                    echo_us_d = meas_us;
                end else begin
                    state_d    = S_IDLE;
                    trig_err_d = 1'b1;
                end
            end
            S_DELAY: begin
                if (tick && (us_q == DELAY_LAST)) state_d = S_ECHO;
            end
            S_ECHO: begin
                if (tick && (us_q == echo_us_q - 16'd1)) state_d = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (tick && (us_q == HOLD_LAST)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Timebase restarts on every transition so timed states are whole microseconds.
        if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_TRIG_HI)) begin
            psc_d = '0;
            us_d  = 16'd0;
        end

        echo_d = (state_d == S_ECHO);
        busy_d = (state_d == S_DELAY) || (state_d == S_ECHO) || (state_d == S_HOLDOFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            trig_s1_q  <= 1'b0;
            ts_q       <= 1'b0;
            ts_dly_q   <= 1'b0;
            hi_cnt_q   <= 16'd0;
            psc_q      <= '0;
            us_q       <= 16'd0;
            echo_us_q  <= 16'd0;
            echo_q     <= 1'b0;
            busy_q     <= 1'b0;
            trig_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_s1_q  <= trig_s1_d;
            ts_q       <= ts_d;
            ts_dly_q   <= ts_dly_d;
            hi_cnt_q   <= hi_cnt_d;
            psc_q      <= psc_d;
            us_q       <= us_d;
            echo_us_q  <= echo_us_d;
            echo_q     <= echo_d;
            busy_q     <= busy_d;
            trig_err_q <= trig_err_d;
        end
    end

    assign echo     = echo_q;
    assign busy     = busy_q;
    assign trig_err = trig_err_q;

endmodule

// File: tb/tb_sonic_echo_emulator.sv
// Purpose: directed self-checking bench for sonic_echo_emulator, using scaled timing
//          parameters (4 clk/us, 20 us delay, 3 us/cm, 1500 us timeout, 50 us holdoff).
// Expected: trig min 40 clk, echo rise 82 clk after E0, 100 cm -> 1200 clk, holdoff 200 clk.
module tb_sonic_echo_emulator;

    localparam int CPU   = 4;
    localparam int LAT   = 20 * CPU + 2;   // E0 -> echo rise
    localparam int HOLD  = 50 * CPU;       // echo fall -> busy fall
    localparam int W100  = 100 * 3 * CPU;  // 1200
    localparam int W2CM  = 2 * 3 * CPU;    // 24
    localparam int W20   = 20 * 3 * CPU;   // 240
    localparam int WTO   = 1500 * CPU;     // 6000

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic [8:0] distance_cm = 9'd100;
    logic       no_object = 1'b0;
    logic       echo, busy, trig_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int e0 = 0;

    // Event log sampled 1 time unit after each rising edge.
    int echo_rise_cyc = 0, echo_fall_cyc = 0, busy_rise_cyc = 0, busy_fall_cyc = 0;
    int n_echo_rise = 0, n_echo_fall = 0, n_busy_rise = 0, n_busy_fall = 0, n_err = 0;
    logic echo_p = 1'b0, busy_p = 1'b0;

    sonic_echo_emulator #(
        .CLK_PER_US(CPU), .MIN_TRIG_US(10), .DELAY_US(20), .US_PER_CM(3),
        .MIN_CM(2), .MAX_CM(400), .TIMEOUT_US(1500), .HOLDOFF_US(50)
    ) dut (
        .clk(clk), .rst(rst), .trig(trig), .distance_cm(distance_cm),
        .no_object(no_object), .echo(echo), .busy(busy), .trig_err(trig_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (echo && !echo_p) begin echo_rise_cyc = cyc; n_echo_rise++; end
        if (!echo && echo_p) begin echo_fall_cyc = cyc; n_echo_fall++; end
        if (busy && !busy_p) begin busy_rise_cyc = cyc; n_busy_rise++; end
        if (!busy && busy_p) begin busy_fall_cyc = cyc; n_busy_fall++; end
        if (trig_err) n_err++;
        echo_p = echo;
        busy_p = busy;
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Raw trig high for exactly w sampling edges; e0 is the first edge that samples it low.
    task automatic pulse_trig(input int w);
        @(posedge clk); #2 trig = 1'b1;
        repeat (w) @(posedge clk);
        #2 trig = 1'b0;
        e0 = cyc + 1;
    endtask

    // which: 0 = echo rise, 1 = echo fall, 2 = busy fall
    task automatic wait_ev(input string tag, input int which, input int budget);
        int start;
        int now;
        bit timed_out;
        start = (which == 0) ? n_echo_rise : (which == 1) ? n_echo_fall : n_busy_fall;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            now = (which == 0) ? n_echo_rise : (which == 1) ? n_echo_fall : n_busy_fall;
            if (now != start) begin
                timed_out = 1'b0;
                break;
            end
        end
        check_eq({tag, "_timeout"}, timed_out, 0);
    endtask

    // Full measurement: trigger, wait for busy to drop, check timing and width.
    task automatic measure(input string tag, input int w, input int exp_width);
        int r0;
        r0 = n_echo_rise;
        pulse_trig(w);
        wait_ev(tag, 2, LAT + exp_width + HOLD + 100);
        check_eq({tag, "_rise_lat"}, echo_rise_cyc - e0, LAT);
        check_eq({tag, "_width"}, echo_fall_cyc - echo_rise_cyc, exp_width);
        check_eq({tag, "_n_echo"}, n_echo_rise - r0, 1);
    endtask

    initial begin
        int err0, er0, br0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_echo", echo, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_trig_err", trig_err, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // Nominal 100 cm measurement with busy framing
        distance_cm = 9'd100;
        measure("d100", 40, W100);
        check_eq("d100_busy_rise", busy_rise_cyc - e0, 2);
        check_eq("d100_busy_hold", busy_fall_cyc - echo_fall_cyc, HOLD);
        check_eq("d100_no_err", n_err, 0);

        // One cycle short trigger is rejected
        er0 = n_echo_rise; br0 = n_busy_rise;
        pulse_trig(39);
        repeat (20) @(posedge clk);
        #2;
        check_eq("short_err_pulses", n_err, 1);
        check_eq("short_no_echo", n_echo_rise - er0, 0);
        check_eq("short_no_busy", n_busy_rise - br0, 0);
        measure("after_short", 40, W100);

        // Clamp and timeout cases
        distance_cm = 9'd0;
        measure("d0_clamp", 40, W2CM);
        distance_cm = 9'd401;
        measure("d401_timeout", 40, WTO);
        distance_cm = 9'd50; no_object = 1'b1;
        measure("no_object", 40, WTO);
        no_object = 1'b0;

        // Triggers during ECHO and HOLDOFF are ignored
        distance_cm = 9'd100;
        err0 = n_err; er0 = n_echo_rise;
        pulse_trig(40);
        begin
            int e0_keep;
            e0_keep = e0;
            wait_ev("ign_rise", 0, LAT + 20);
            repeat (100) @(posedge clk);
            pulse_trig(40);                       // inside ECHO
            wait_ev("ign_fall", 1, W100 + 20);
            pulse_trig(40);                       // inside HOLDOFF
            wait_ev("ign_busy", 2, HOLD + 20);
            check_eq("ign_rise_lat", echo_rise_cyc - e0_keep, LAT);
        end
        check_eq("ign_width", echo_fall_cyc - echo_rise_cyc, W100);
        check_eq("ign_no_err", n_err - err0, 0);
        check_eq("ign_n_echo", n_echo_rise - er0, 1);
        measure("after_busy", 40, W100);

        // Distance change during DELAY does not affect latched width
        distance_cm = 9'd100;
        er0 = n_echo_rise;
        pulse_trig(40);
        repeat (20) @(posedge clk);
        #2 distance_cm = 9'd10;
        wait_ev("chg_busy", 2, LAT + W100 + HOLD + 100);
        check_eq("chg_width", echo_fall_cyc - echo_rise_cyc, W100);
        check_eq("chg_n_echo", n_echo_rise - er0, 1);

        // Async reset mid-ECHO
        distance_cm = 9'd100;
        pulse_trig(40);
        wait_ev("rstmid_rise", 0, LAT + 20);
        repeat (50) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("rstmid_echo", echo, 0);
        check_eq("rstmid_busy", busy, 0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        distance_cm = 9'd20;
        measure("d20_after_rst", 40, W20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
